// File: rtl/dac_source_arbiter.sv
// Arbitrates the sweep generator and the PML NCO path onto one DAC serializer, muting the
// output to mid-scale for a fixed interval whenever ownership changes.
module dac_source_arbiter #(
  parameter int unsigned MUTE_CYCLES = 16,
  parameter logic [15:0] MIDSCALE    = 16'h8000
) (
  input  logic               clk_50,
  input  logic               reset_n,
  input  logic               sweep_req,
  input  logic signed [15:0] sweep_data,
  input  logic               sweep_valid,
  input  logic               pml_req,
  input  logic signed [15:0] pml_data,
  input  logic               pml_valid,
  input  logic               stop_cmd,
  input  logic               dac_busy,
  output logic [15:0]        dac_data,
  output logic               dac_start,
  output logic [1:0]         grant,
  output logic               running
);

  typedef enum logic [1:0] {
    StIdle       = 2'b00,
    StGrantSweep = 2'b01,
    StGrantPml   = 2'b10,
    StSwitch     = 2'b11
  } state_e;

  localparam logic [7:0] MuteLast = 8'(MUTE_CYCLES - 1);

  state_e      state_q, state_d;
  state_e      target_q, target_d;
  logic [7:0]  mute_cnt_q, mute_cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] dac_data_q, dac_data_d;
  logic        pending_q, pending_d;
  logic        start_q, start_d;
  logic        lock_sweep_q, lock_sweep_d;
  logic        lock_pml_q, lock_pml_d;
  logic        sweep_ok, pml_ok, enter_switch;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      target_q     <= StIdle;
      mute_cnt_q   <= '0;
      hold_q       <= MIDSCALE;
      dac_data_q   <= MIDSCALE;
      pending_q    <= 1'b0;
      start_q      <= 1'b0;
      lock_sweep_q <= 1'b0;
      lock_pml_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      mute_cnt_q   <= mute_cnt_d;
      hold_q       <= hold_d;
      dac_data_q   <= dac_data_d;
      pending_q    <= pending_d;
      start_q      <= start_d;
      lock_sweep_q <= lock_sweep_d;
      lock_pml_q   <= lock_pml_d;
    end
  end

  always_comb begin
    sweep_ok     = sweep_req & ~lock_sweep_q;
    pml_ok       = pml_req & ~lock_pml_q;
    state_d      = state_q;
    target_d     = target_q;
    mute_cnt_d   = mute_cnt_q;
    hold_d       = hold_q;
    pending_d    = pending_q;
    dac_data_d   = dac_data_q;
    enter_switch = 1'b0;
    // A lockout only survives while its request stays high.
    lock_sweep_d = lock_sweep_q & sweep_req;
    lock_pml_d   = lock_pml_q & pml_req;

    // Launch one cycle after a pending sample meets an idle serializer; never back-to-back.
    start_d = pending_q & ~dac_busy & ~start_q;
    if (start_d) begin
      dac_data_d = hold_q;
      pending_d  = 1'b0;
    end

    if (stop_cmd) begin
      lock_sweep_d = sweep_req;
      lock_pml_d   = pml_req;
      enter_switch = (state_q != StSwitch);
      state_d      = StSwitch;
      target_d     = StIdle;
      mute_cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pml_ok) begin
            enter_switch = 1'b1;
            target_d     = StGrantPml;
          end else if (sweep_ok) begin
            enter_switch = 1'b1;
            target_d     = StGrantSweep;
          end
        end
        StGrantSweep: begin
          if (pml_ok) begin
            enter_switch = 1'b1;
            target_d     = StGrantPml;
          end else if (!sweep_req) begin
            enter_switch = 1'b1;
            target_d     = StIdle;
          end else if (sweep_valid) begin
            hold_d    = sweep_data ^ 16'h8000;
            pending_d = 1'b1;
          end
        end
        StGrantPml: begin
          if (!pml_req) begin
            enter_switch = 1'b1;
            target_d     = sweep_ok ? StGrantSweep : StIdle;
          end else if (pml_valid) begin
            hold_d    = pml_data ^ 16'h8000;
            pending_d = 1'b1;
          end
        end
        StSwitch: begin
          if (mute_cnt_q == MuteLast) begin
            state_d    = target_q;
            mute_cnt_d = '0;
          end else begin
            mute_cnt_d = mute_cnt_q + 8'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Every entry into the mute interval queues a mid-scale conversion.
    if (enter_switch) begin
      state_d    = StSwitch;
      mute_cnt_d = '0;
      hold_d     = MIDSCALE;
      pending_d  = 1'b1;
    end
  end

  assign dac_data  = dac_data_q;
  assign dac_start = start_q;
  assign grant     = state_q;
  assign running   = (state_q == StGrantSweep) || (state_q == StGrantPml);

endmodule

// File: tb/tb_dac_source_arbiter.sv
// Directed and randomized bench for dac_source_arbiter against a cycle-level reference model.
module tb_dac_source_arbiter;

  localparam int MUTE = 16;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        sweep_req = 1'b0, sweep_valid = 1'b0;
  logic [15:0] sweep_data = '0;
  logic        pml_req = 1'b0, pml_valid = 1'b0;
  logic [15:0] pml_data = '0;
  logic        stop_cmd = 1'b0, dac_busy = 1'b0;
  logic [15:0] dac_data;
  logic        dac_start;
  logic [1:0]  grant;
  logic        running;

  dac_source_arbiter dut (
    .clk_50     (clk_50),
    .reset_n    (reset_n),
    .sweep_req  (sweep_req),
    .sweep_data (sweep_data),
    .sweep_valid(sweep_valid),
    .pml_req    (pml_req),
    .pml_data   (pml_data),
    .pml_valid  (pml_valid),
    .stop_cmd   (stop_cmd),
    .dac_busy   (dac_busy),
    .dac_data   (dac_data),
    .dac_start  (dac_start),
    .grant      (grant),
    .running    (running)
  );

  always #10 clk_50 = ~clk_50;

  int checks = 0;
  int errors = 0;

  // Reference model: owner is 0 none / 1 sweep / 2 PML / 3 muting.
  int          m_owner, m_dest, m_muted;
  logic [15:0] m_latest, m_out;
  bit          m_waiting, m_start, m_lock_s, m_lock_p;
  int          n_owner, n_dest, n_muted;
  logic [15:0] n_latest, n_out;
  bit          n_waiting, n_start, n_lock_s, n_lock_p;

  bit busy_manual = 1'b0;
  int ser_left = 0;
  bit prev_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_dest = 0; m_muted = 0; m_latest = 16'h8000; m_out = 16'h8000;
    m_waiting = 0; m_start = 0; m_lock_s = 0; m_lock_p = 0;
  endtask

  task automatic begin_mute(input int dest);
    n_owner = 3; n_dest = dest; n_muted = 0; n_latest = 16'h8000; n_waiting = 1;
  endtask

  task automatic model_step();
    bit s_ok, p_ok;
    n_owner = m_owner; n_dest = m_dest; n_muted = m_muted; n_latest = m_latest;
    n_out = m_out; n_waiting = m_waiting;
    if (!reset_n) begin
      n_owner = 0; n_dest = 0; n_muted = 0; n_latest = 16'h8000; n_out = 16'h8000;
      n_waiting = 0; n_start = 0; n_lock_s = 0; n_lock_p = 0;
      return;
    end
    s_ok = sweep_req && !m_lock_s;
    p_ok = pml_req && !m_lock_p;
    n_lock_s = m_lock_s && sweep_req;
    n_lock_p = m_lock_p && pml_req;
    n_start = m_waiting && !dac_busy && !m_start;
    if (n_start) begin
      n_out = m_latest;
      n_waiting = 0;
    end
    if (stop_cmd) begin
      n_lock_s = sweep_req;
      n_lock_p = pml_req;
      if (m_owner != 3) begin_mute(0);
      else begin n_dest = 0; n_muted = 0; end
    end else if (m_owner == 0) begin
      if (p_ok) begin_mute(2);
      else if (s_ok) begin_mute(1);
    end else if (m_owner == 1) begin
      if (p_ok) begin_mute(2);
      else if (!sweep_req) begin_mute(0);
      else if (sweep_valid) begin n_latest = sweep_data + 16'h8000; n_waiting = 1; end
    end else if (m_owner == 2) begin
      if (!pml_req) begin_mute(s_ok ? 1 : 0);
      else if (pml_valid) begin n_latest = pml_data + 16'h8000; n_waiting = 1; end
    end else begin
      n_muted = m_muted + 1;
      if (n_muted == MUTE) begin n_owner = m_dest; n_muted = 0; end
    end
  endtask

  task automatic check_outputs();
    chk("grant", {30'd0, grant}, m_owner);
    chk("running", {31'd0, running}, (m_owner == 1 || m_owner == 2) ? 1 : 0);
    chk("dac_start", {31'd0, dac_start}, {31'd0, m_start});
    chk("dac_data", {16'd0, dac_data}, {16'd0, m_out});
    chk("start_while_busy", {31'd0, dac_start & dac_busy}, 0);
    chk("start_back_to_back", {31'd0, dac_start & prev_start}, 0);
    prev_start = dac_start;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_50);
    #1;
    m_owner = n_owner; m_dest = n_dest; m_muted = n_muted; m_latest = n_latest;
    m_out = n_out; m_waiting = n_waiting; m_start = n_start;
    m_lock_s = n_lock_s; m_lock_p = n_lock_p;
    check_outputs();
    if (!busy_manual) begin
      // Serializer model: busy rises the cycle after a start for a random length.
      dac_busy = (ser_left > 0);
      if (ser_left > 0) ser_left--;
      if (dac_start) ser_left = $urandom_range(0, 5);
    end
  endtask

  initial begin
    int sw_cycles, n_starts;
    bit saw_mid;
    logic [15:0] start_val;
    model_reset();

    // Reset state
    tick(); tick();
    chk("reset_grant", {30'd0, grant}, 0);
    chk("reset_data", {16'd0, dac_data}, 32'h8000);
    reset_n = 1'b1;
    tick();

    // Sweep grant through the mute interval, then a sample
    sweep_req = 1'b1;
    tick();
    chk("sweep_enter_switch", {30'd0, grant}, 3);
    sw_cycles = 1; saw_mid = 0;
    for (int i = 0; i < 40 && grant == 2'b11; i++) begin
      tick();
      if (grant == 2'b11) sw_cycles++;
      if (dac_start && dac_data == 16'h8000) saw_mid = 1;
    end
    chk("mute_length", sw_cycles, MUTE);
    chk("mute_midscale_start", {31'd0, saw_mid}, 1);
    chk("sweep_granted", {30'd0, grant}, 1);
    sweep_data = 16'h0100; sweep_valid = 1'b1;
    tick();
    sweep_valid = 1'b0;
    tick();
    chk("sweep_latency_start", {31'd0, dac_start}, 1);
    chk("sweep_latency_data", {16'd0, dac_data}, 32'h8100);

    // PML preempts sweep
    pml_req = 1'b1;
    tick();
    chk("preempt_switch", {30'd0, grant}, 3);
    for (int i = 0; i < 40 && grant == 2'b11; i++) tick();
    chk("pml_granted", {30'd0, grant}, 2);
    pml_data = 16'hFF00; pml_valid = 1'b1;
    tick();
    pml_valid = 1'b0;
    tick();
    chk("pml_data_ff00", {16'd0, dac_data}, 32'h7F00);

    // Busy serializer: only the newest of three samples is converted
    tick(); tick(); tick();
    busy_manual = 1'b1; dac_busy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      pml_data = 16'(k); pml_valid = 1'b1;
      tick();
    end
    pml_valid = 1'b0;
    tick(); tick();
    dac_busy = 1'b0;
    n_starts = 0; start_val = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (dac_start) begin n_starts++; start_val = dac_data; end
    end
    chk("busy_single_start", n_starts, 1);
    chk("busy_latest_wins", {16'd0, start_val}, 32'h8003);
    busy_manual = 1'b0; ser_left = 0;

    // Stop with pml_req held: lockout until req drops for a cycle
    sweep_req = 1'b0;
    stop_cmd = 1'b1;
    tick();
    stop_cmd = 1'b0;
    chk("stop_switch", {30'd0, grant}, 3);
    for (int i = 0; i < 30; i++) tick();
    chk("stop_locked_idle", {30'd0, grant}, 0);
    pml_req = 1'b0;
    tick();
    pml_req = 1'b1;
    tick();
    chk("relock_switch", {30'd0, grant}, 3);
    for (int i = 0; i < 20; i++) tick();
    chk("regrant_pml", {30'd0, grant}, 2);

    // Hand over to sweep, then stop coincident with a sweep strobe
    sweep_req = 1'b1; pml_req = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("handover_sweep", {30'd0, grant}, 1);
    stop_cmd = 1'b1; sweep_valid = 1'b1; sweep_data = 16'h1234;
    tick();
    stop_cmd = 1'b0; sweep_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("stop_discards_sample", {16'd0, dac_data}, 32'h8000);

    // Asynchronous reset mid-mute
    #3 reset_n = 1'b0;
    #1;
    chk("async_grant", {30'd0, grant}, 0);
    chk("async_running", {31'd0, running}, 0);
    chk("async_start", {31'd0, dac_start}, 0);
    chk("async_data", {16'd0, dac_data}, 32'h8000);
    model_reset();
    prev_start = 1'b0;
    tick(); tick();
    sweep_req = 1'b0;
    reset_n = 1'b1;
    n_starts = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dac_start) n_starts++;
    end
    chk("no_start_after_reset", n_starts, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) sweep_req = ~sweep_req;
      if ($urandom_range(0, 24) == 0) pml_req = ~pml_req;
      sweep_valid = ($urandom_range(0, 3) == 0);
      pml_valid   = ($urandom_range(0, 3) == 0);
      sweep_data  = 16'($urandom);
      pml_data    = 16'($urandom);
      stop_cmd    = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_source_arbiter.md
DAC_SOURCE_ARBITER -- requirements
Module: dac_source_arbiter

Interface
REQ-001 Parameter MUTE_CYCLES, default 16: clocks spent in SWITCH at mid-scale before a new grant takes effect (range 1..255).
REQ-002 Parameter MIDSCALE, default 16'h8000: offset-binary code for 0 V.
REQ-003 clk_50  in  1  single system clock; all logic on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 sweep_req  in  1  level; sweep generator requests the DAC.
REQ-006 sweep_data  in  16  signed two's-complement sweep sample.
REQ-007 sweep_valid  in  1  one-cycle strobe qualifying sweep_data.
REQ-008 pml_req  in  1  level; PML NCO path requests the DAC.
REQ-009 pml_data  in  16  signed PML sample.
REQ-010 pml_valid  in  1  strobe qualifying pml_data.
REQ-011 stop_cmd  in  1  one-cycle pulse; abort the active source.
REQ-012 dac_busy  in  1  DAC serializer busy; high while a conversion is shifting out.
REQ-013 dac_data  out  16  offset-binary word to the serializer; held stable while dac_busy is high.
REQ-014 dac_start  out  1  one-cycle pulse launching a conversion of dac_data.
REQ-015 grant  out  2  00 none, 01 sweep, 10 PML, 11 switching.
REQ-016 running  out  1  high when grant is 01 or 10.

Function
REQ-017 States IDLE, GRANT_SWEEP, GRANT_PML, SWITCH; grant encodes the state.
REQ-018 Priority: PML over sweep. In IDLE, pml_req (not locked out) -> SWITCH targeting PML; else sweep_req (not locked out) -> SWITCH targeting sweep.
REQ-019 In GRANT_SWEEP, pml_req assertion preempts: -> SWITCH targeting PML. GRANT_PML is never preempted by sweep.
REQ-020 Deassertion of the granted source's req -> SWITCH targeting IDLE, unless the other req is asserted and not locked out, in which case the target is that source.
REQ-021 SWITCH loads mid-scale into the hold register with a pending conversion on entry, counts MUTE_CYCLES clocks, then enters the target state; samples from any source are discarded while in SWITCH.
REQ-022 In a GRANT state, each valid strobe from the granted source loads (data XOR 16'h8000) into the hold register and sets pending; valid strobes from the non-granted source are ignored.
REQ-023 A new valid while pending is already set overwrites the hold register (latest sample wins); no queueing.
REQ-024 dac_start pulses in the cycle after the first cycle in which pending=1 and dac_busy=0; pending clears in that same cycle; dac_data updates from the hold register only on that start.
REQ-025 dac_start shall never assert while dac_busy is high, nor on two consecutive cycles.
REQ-026 stop_cmd in any state -> SWITCH targeting IDLE, and sets a lockout for each source whose req is high; a locked-out source is not granted until its req has been low for at least one cycle.
REQ-027 stop_cmd coincident with a req rising or a valid strobe: stop wins; the sample is discarded.
REQ-028 stop_cmd during SWITCH retargets to IDLE and restarts the MUTE_CYCLES count.
REQ-029 Latency: sweep_valid in cycle N with dac_busy low and a GRANT state -> dac_start and new dac_data in cycle N+2.

Reset
REQ-030 On reset_n low, immediately: state IDLE, dac_data=MIDSCALE, hold register=MIDSCALE, pending=0, dac_start=0, grant=00, running=0, counter=0, lockouts cleared.
REQ-031 Reset mid-conversion or mid-SWITCH abandons the operation; no dac_start is generated until a new sample becomes pending after release.
REQ-032 Release of reset_n is taken synchronously to clk_50; first arbitration occurs on the first edge after release.

Verification
REQ-033 sweep_req=1, dac_busy=0, sweep_valid with 16'h0100 after SWITCH -> grant 11 for 16 clocks with dac_start of 16'h8000, then grant 01, dac_start with dac_data=16'h8100 two cycles after the strobe.
REQ-034 GRANT_SWEEP, pml_req rises -> grant 11, mid-scale conversion, 16 clocks later grant 10; pml_data 16'hFF00 -> dac_data=16'h7F00.
REQ-035 GRANT_PML, dac_busy held high, three pml_valid strobes (1,2,3) -> single dac_start after busy falls with dac_data=16'h8003.
REQ-036 stop_cmd with pml_req held high -> IDLE via SWITCH, no re-grant while pml_req stays high; pml_req low one cycle then high -> re-grant to PML.
REQ-037 stop_cmd and sweep_valid in the same cycle -> sample discarded, dac_data reaches 16'h8000; reset_n pulsed low mid-SWITCH -> all outputs at reset values asynchronously.
